dsp_conv_engine: RTL and testbench
==================================

// Module: dsp_conv_engine
// PURPOSE
//  Memory-mapped 1-D convolution accelerator: y[n] = sum_k h[k]*x[n-k], n = 0..X_LEN+H_LEN-2.
//  CPU programs base addresses/lengths via register port, sets START, polls STATUS.
//  Engine masters DATA_MEM through an arbitrated word port, reads x/h, writes y, flags DONE.
// PARAMETERS
//  DATA_W  32  sample/coeff/result width, signed two's complement
//  ADDR_W  8   DATA_MEM word-address width; also width of length registers
//  ACC_W   72  accumulator width (>= 2*DATA_W + ADDR_W)
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high
//  reg_sel    in   1       register access strobe
//  reg_we     in   1       1 = write, 0 = read
//  reg_addr   in   3       register index (map below)
//  reg_wdata  in   DATA_W  register write data
//  reg_rdata  out  DATA_W  register read data, combinational from reg_addr
//  mem_req    out  1       memory request
//  mem_we     out  1       1 = write, 0 = read
//  mem_addr   out  ADDR_W  word address
//  mem_wdata  out  DATA_W  write data
//  mem_gnt    in   1       arbiter grant; request completes in cycle req&gnt
//  mem_rdata  in   DATA_W  read data, valid cycle after granted read
//  done_irq   out  1       level, equals STATUS.DONE
// BEHAVIOUR
//  Regs: 0 CTRL(W: b0 START, self-clearing) 1 STATUS(R: b0 BUSY b1 DONE b2 ERR; W1C b1,b2)
//   2 X_BASE 3 H_BASE 4 Y_BASE 5 X_LEN 6 H_LEN (RW, ADDR_W LSBs) 7 OUT_CNT (R: outputs written).
//  Reset: all regs 0, FSM IDLE, mem_req/mem_we/done_irq 0, mem_addr/mem_wdata 0.
//  Writes to regs 2-6 and START ignored while BUSY; reads always allowed.
//  FSM: IDLE -START-> INIT (acc=0,n=0,k=0,OUT_CNT=0,DONE/ERR cleared, BUSY=1).
//   INIT: X_LEN==0 or H_LEN==0 -> DONE state with ERR=1, no mem traffic; else TAP.
//   TAP: k>=H_LEN -> WR; (n-k)<0 or (n-k)>=X_LEN -> k++, stay (1 cycle); else RD_H.
//   RD_H: req read H_BASE+k, hold until gnt -> RD_X.
//   RD_X: latch h from mem_rdata in first cycle; req read X_BASE+(n-k), hold until gnt -> MAC.
//   MAC: acc += h*x (x = mem_rdata, signed full-precision product), k++ -> TAP.
//   WR: req write Y_BASE+n, data = result(acc); on gnt: OUT_CNT++, acc=0, k=0, n++;
//       last output -> DONE else TAP.
//   DONE: BUSY=0, DONE=1 -> IDLE.
//  Request signals stable while mem_req & !mem_gnt; mem_req low in IDLE/INIT/TAP/MAC/DONE.
//  Address arithmetic modulo 2^ADDR_W (wraps silently). Output count = X_LEN+H_LEN-1 (ADDR_W+1 bits).
//  Cost with mem_gnt=1: 4 cycles/valid tap, 1/skipped tap, 2/output, +2 start/finish.
//  Reset mid-operation: immediate abort, mem_req drops asynchronously, no completion flagged.
//  START write coincident with STATUS W1C: START wins (flags cleared by INIT anyway).
// CONFIGURATION
//  DSP_CONV_SAT_EN defined: result = acc saturated to signed DATA_W range.
//  Undefined: result = acc[DATA_W-1:0] (wrap-around truncation).
// TESTING
//  x={1,2,3} @0x10, h={1,1} @0x20, Y_BASE 0x30, START -> mem[0x30..0x33]={1,3,5,3}, OUT_CNT=4, DONE=1, busy<=40 cycles.
//  x={-3}, h={5} -> y[0]=0xFFFFFFF1; single output, ERR=0.
//  x={0x7FFFFFFF}, h={2} -> y[0]=0x7FFFFFFF with DSP_CONV_SAT_EN, 0xFFFFFFFE without.
//  X_LEN=0, START -> DONE=1, ERR=1 within 3 cycles, mem_req never asserted; W1C clears both.
//  mem_gnt randomly low 50% -> same y as gnt=1; mem_addr/we/wdata stable during stalls; write X_BASE while BUSY ignored.
//  reset pulse mid-run then re-START -> clean complete run, correct y, OUT_CNT restarts from 0.

Source files
------------

// File: rtl/dsp_conv_engine_if.sv
// Register port (CPU side) and arbitrated data-memory word port of the convolution engine.
// The engine uses the slave modport; the CPU/memory system side uses master.
interface dsp_conv_engine_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              reg_sel;
    logic              reg_we;
    logic [2:0]        reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic [DATA_W-1:0] mem_rdata;
    logic              done_irq;

    modport slave (
        input  reg_sel, reg_we, reg_addr, reg_wdata, mem_gnt, mem_rdata,
        output reg_rdata, mem_req, mem_we, mem_addr, mem_wdata, done_irq
    );

    modport master (
        output reg_sel, reg_we, reg_addr, reg_wdata, mem_gnt, mem_rdata,
        input  reg_rdata, mem_req, mem_we, mem_addr, mem_wdata, done_irq
    );
endinterface

// File: rtl/dsp_conv_engine.sv
// Memory-mapped 1-D convolution engine: y[n] = sum_k h[k]*x[n-k], one memory word per access.
// Build option: define DSP_CONV_SAT_EN to saturate results to DATA_W instead of truncating.
module dsp_conv_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned ACC_W  = 72
) (
    input  logic             clock,
    input  logic             reset,
    dsp_conv_engine_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DIF_W = ADDR_W + 2;
    localparam int unsigned PRD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_TAP, S_RD_H, S_RD_X, S_MAC, S_WR, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        x_base_q, x_base_d, h_base_q, h_base_d, y_base_q, y_base_d;
    logic [ADDR_W-1:0]        x_len_q, x_len_d, h_len_q, h_len_d;
    logic [CNT_W-1:0]         out_cnt_q, out_cnt_d, n_q, n_d, k_q, k_d;
    logic                     busy_q, busy_d, done_q, done_d, err_q, err_d, first_q, first_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        h_q, h_d;
    logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;

    logic                     reg_wr, start, tap_skip, taps_done, last_out, unused_wdata;
    logic signed [DIF_W-1:0]  tap_idx;
    logic [CNT_W-1:0]         out_total;
    logic signed [PRD_W-1:0]  prod;
    logic [DATA_W-1:0]        result;

    assign reg_wr       = bus.reg_sel & bus.reg_we;
    assign start        = reg_wr && (bus.reg_addr == 3'd0) && bus.reg_wdata[0] && !busy_q;
    assign unused_wdata = ^bus.reg_wdata[DATA_W-1:ADDR_W];

    // x index for the current tap; negative or past X_LEN means the tap contributes nothing
    assign tap_idx   = $signed({1'b0, n_q}) - $signed({1'b0, k_q});
    assign tap_skip  = tap_idx[DIF_W-1] || (tap_idx >= $signed({2'b00, x_len_q}));
    assign taps_done = k_q >= {1'b0, h_len_q};
    assign out_total = {1'b0, x_len_q} + {1'b0, h_len_q} - CNT_W'(1);
    assign last_out  = (n_q + CNT_W'(1)) == out_total;
    assign prod      = PRD_W'($signed(h_q)) * PRD_W'($signed(bus.mem_rdata));

`ifdef DSP_CONV_SAT_EN
    // Clamp when the accumulator's upper bits are not a pure sign extension
    always_comb begin
        if (acc_q[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){acc_q[ACC_W-1]}}) begin
            result = acc_q[DATA_W-1:0];
        end else if (acc_q[ACC_W-1]) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign result = acc_q[DATA_W-1:0];
`endif

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            3'd1:    bus.reg_rdata = DATA_W'({err_q, done_q, busy_q});
            3'd2:    bus.reg_rdata = DATA_W'(x_base_q);
            3'd3:    bus.reg_rdata = DATA_W'(h_base_q);
            3'd4:    bus.reg_rdata = DATA_W'(y_base_q);
            3'd5:    bus.reg_rdata = DATA_W'(x_len_q);
            3'd6:    bus.reg_rdata = DATA_W'(h_len_q);
            3'd7:    bus.reg_rdata = DATA_W'(out_cnt_q);
            default: bus.reg_rdata = '0;
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done_irq  = done_q;

    always_comb begin
        state_d     = state_q;
        x_base_d    = x_base_q;
        h_base_d    = h_base_q;
        y_base_d    = y_base_q;
        x_len_d     = x_len_q;
        h_len_d     = h_len_q;
        out_cnt_d   = out_cnt_q;
        n_d         = n_q;
        k_d         = k_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        first_d     = first_q;
        acc_d       = acc_q;
        h_d         = h_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // Configuration registers are frozen while a run is in progress
        if (reg_wr) begin
            case (bus.reg_addr)
                3'd1: begin
                    if (bus.reg_wdata[1]) done_d = 1'b0;
                    if (bus.reg_wdata[2]) err_d  = 1'b0;
                end
                3'd2: if (!busy_q) x_base_d = bus.reg_wdata[ADDR_W-1:0];
                3'd3: if (!busy_q) h_base_d = bus.reg_wdata[ADDR_W-1:0];
                3'd4: if (!busy_q) y_base_d = bus.reg_wdata[ADDR_W-1:0];
                3'd5: if (!busy_q) x_len_d  = bus.reg_wdata[ADDR_W-1:0];
                3'd6: if (!busy_q) h_len_d  = bus.reg_wdata[ADDR_W-1:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_INIT;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    acc_d     = '0;
                    n_d       = '0;
                    k_d       = '0;
                    out_cnt_d = '0;
                end
            end
            S_INIT: begin
                if ((x_len_q == '0) || (h_len_q == '0)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_TAP;
                end
            end
            S_TAP: begin
                if (taps_done) begin
                    state_d     = S_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = y_base_q + n_q[ADDR_W-1:0];
                    mem_wdata_d = result;
                end else if (tap_skip) begin
                    k_d = k_q + CNT_W'(1);
                end else begin
                    state_d    = S_RD_H;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = h_base_q + k_q[ADDR_W-1:0];
                end
            end
            S_RD_H: begin
                if (bus.mem_gnt) begin
                    state_d    = S_RD_X;
                    first_d    = 1'b1;
                    mem_addr_d = x_base_q + tap_idx[ADDR_W-1:0];
                end
            end
            S_RD_X: begin
                // Coefficient read data is only on the bus in the first RD_X cycle
                first_d = 1'b0;
                if (first_q) h_d = bus.mem_rdata;
                if (bus.mem_gnt) begin
                    state_d   = S_MAC;
                    mem_req_d = 1'b0;
                end
            end
            S_MAC: begin
                acc_d   = acc_q + ACC_W'(prod);
                k_d     = k_q + CNT_W'(1);
                state_d = S_TAP;
            end
            S_WR: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    acc_d     = '0;
                    k_d       = '0;
                    n_d       = n_q + CNT_W'(1);
                    state_d   = last_out ? S_DONE : S_TAP;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_base_q    <= '0;
            h_base_q    <= '0;
            y_base_q    <= '0;
            x_len_q     <= '0;
            h_len_q     <= '0;
            out_cnt_q   <= '0;
            n_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            acc_q       <= '0;
            h_q         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            x_base_q    <= x_base_d;
            h_base_q    <= h_base_d;
            y_base_q    <= y_base_d;
            x_len_q     <= x_len_d;
            h_len_q     <= h_len_d;
            out_cnt_q   <= out_cnt_d;
            n_q         <= n_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            h_q         <= h_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
endmodule

// File: tb/tb_dsp_conv_engine.sv
// Directed bench for dsp_conv_engine: a table of convolutions run through a word-memory model,
// plus sequences for zero length, busy-time writes, grant stalls and mid-run reset.
module tb_dsp_conv_engine;
    localparam int NV = 7;

`ifdef DSP_CONV_SAT_EN
    localparam logic [31:0] E_OVF_A = 32'h7FFFFFFF;  // 0x7FFFFFFF * 2
    localparam logic [31:0] E_OVF_B = 32'h7FFFFFFF;  // 0x10000 * 0x10000 = 2^32
    localparam logic [31:0] E_OVF_C = 32'h7FFFFFFF;  // -2^31 * -1 = 2^31
`else
    localparam logic [31:0] E_OVF_A = 32'hFFFFFFFE;
    localparam logic [31:0] E_OVF_B = 32'h00000000;
    localparam logic [31:0] E_OVF_C = 32'h80000000;
`endif

    typedef struct packed {
        logic [7:0]       xb, hb, yb, xl, hl;
        logic [3:0][31:0] x;     // {x3, x2, x1, x0}
        logic [3:0][31:0] h;     // {h3, h2, h1, h0}
        logic [7:0][31:0] y;     // {y7 .. y0}, expected outputs
        logic             rnd;   // random grant stalls
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    dsp_conv_engine_if #(.DATA_W(32), .ADDR_W(8)) bus ();
    dsp_conv_engine dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    logic [31:0] mem [256];
    logic        host_we = 1'b0;
    logic [7:0]  host_addr;
    logic [31:0] host_data;
    logic        g_l = 1'b0, we_l = 1'b0;
    logic [7:0]  a_l;
    logic [31:0] d_l;
    logic        rnd_gnt = 1'b0;
    logic        stall_q = 1'b0, p_we;
    logic [7:0]  p_addr;
    logic [31:0] p_wdata;
    int          stab_viol = 0, stab_checks = 0, req_seen = 0;
    int          checks = 0, errors = 0;
    vec_t        vecs [NV];

    // Bus sampling away from the active edge: latch the transfer, check stall stability
    always @(negedge clock) begin
        g_l  = bus.mem_req & bus.mem_gnt;
        we_l = bus.mem_we;
        a_l  = bus.mem_addr;
        d_l  = bus.mem_wdata;
        if (bus.mem_req === 1'b1) req_seen++;
        if (stall_q && !reset) begin
            stab_checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== p_addr || bus.mem_we !== p_we ||
                bus.mem_wdata !== p_wdata) stab_viol++;
        end
        stall_q = !reset && (bus.mem_req === 1'b1) && (bus.mem_gnt !== 1'b1);
        p_addr  = bus.mem_addr;
        p_we    = bus.mem_we;
        p_wdata = bus.mem_wdata;
    end

    always @(posedge clock) begin
        if (host_we) mem[host_addr] <= host_data;
        else if (g_l && we_l) mem[a_l] <= d_l;
        bus.mem_rdata <= (g_l && !we_l) ? mem[a_l] : 32'hDEADBEEF;
    end

    always @(posedge clock) begin
        #1;
        bus.mem_gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic vec_t mk(input logic [7:0] xb, hb, yb, xl, hl,
                                input logic [127:0] x, h, input logic [255:0] y, input logic rnd);
        vec_t m;
        m.xb = xb; m.hb = hb; m.yb = yb; m.xl = xl; m.hl = hl;
        m.x = x; m.h = h; m.y = y; m.rnd = rnd;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.reg_sel = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
        @(negedge clock);
        bus.reg_sel = 1'b0; bus.reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clock);
        bus.reg_addr = a; bus.reg_sel = 1'b1; bus.reg_we = 1'b0;
        #1 d = bus.reg_rdata;
        bus.reg_sel = 1'b0;
    endtask

    task automatic mem_fill(input vec_t v);
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            host_we = 1'b1; host_addr = 8'(i); host_data = 32'hA5000000 | 32'(i);
        end
        for (int i = 0; i < int'(v.xl); i++) begin
            @(negedge clock);
            host_addr = v.xb + 8'(i); host_data = v.x[i];
        end
        for (int i = 0; i < int'(v.hl); i++) begin
            @(negedge clock);
            host_addr = v.hb + 8'(i); host_data = v.h[i];
        end
        @(negedge clock);
        host_we = 1'b0;
    endtask

    task automatic program_vec(input vec_t v);
        reg_write(3'd2, 32'(v.xb));
        reg_write(3'd3, 32'(v.hb));
        reg_write(3'd4, 32'(v.yb));
        reg_write(3'd5, 32'(v.xl));
        reg_write(3'd6, 32'(v.hl));
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (bus.done_irq !== 1'b1 && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic check_result(input vec_t v, input string tag);
        int          yl;
        logic [31:0] s;
        yl = int'(v.xl) + int'(v.hl) - 1;
        check({tag, "_done"}, 32'(bus.done_irq), 32'd1);
        for (int i = 0; i < yl; i++)
            check($sformatf("%s_y%0d", tag, i), mem[v.yb + 8'(i)], v.y[i]);
        reg_read(3'd7, s);
        check({tag, "_out_cnt"}, s, 32'(yl));
        reg_read(3'd1, s);
        check({tag, "_status"}, s, 32'd2);
    endtask

    task automatic run_vec(input vec_t v, input string tag, output int cyc);
        mem_fill(v);
        rnd_gnt = v.rnd;
        program_vec(v);
        reg_write(3'd0, 32'd1);
        wait_done(2000, cyc);
        check_result(v, tag);
    endtask

    initial begin
        logic [31:0] s;
        int          cyc, c, req0;

        reset = 1'b1;
        bus.reg_sel = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = 3'd0; bus.reg_wdata = '0;
        vecs[0] = mk(8'h10, 8'h20, 8'h30, 8'd3, 8'd2, {32'd0, 32'd3, 32'd2, 32'd1},
                     {32'd0, 32'd0, 32'd1, 32'd1},
                     {32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd5, 32'd3, 32'd1}, 1'b0);
        vecs[1] = mk(8'h10, 8'h20, 8'h30, 8'd1, 8'd1, {96'd0, 32'hFFFFFFFD}, {96'd0, 32'd5},
                     {224'd0, 32'hFFFFFFF1}, 1'b0);
        vecs[2] = mk(8'h10, 8'h20, 8'h30, 8'd1, 8'd1, {96'd0, 32'h7FFFFFFF}, {96'd0, 32'd2},
                     {224'd0, E_OVF_A}, 1'b0);
        // x wraps FE,FF,00; taps {3,0,-2} against {2,-1,4}
        vecs[3] = mk(8'hFE, 8'h40, 8'h60, 8'd3, 8'd3, {32'd0, 32'd4, 32'hFFFFFFFF, 32'd2},
                     {32'd0, 32'hFFFFFFFE, 32'd0, 32'd3},
                     {96'd0, 32'hFFFFFFF8, 32'd2, 32'd8, 32'hFFFFFFFD, 32'd6}, 1'b1);
        // y wraps FF,00
        vecs[4] = mk(8'h10, 8'h20, 8'hFF, 8'd2, 8'd1, {64'd0, 32'h10000, 32'h10000},
                     {96'd0, 32'h10000}, {192'd0, E_OVF_B, E_OVF_B}, 1'b1);
        vecs[5] = mk(8'h10, 8'h20, 8'h30, 8'd1, 8'd1, {96'd0, 32'h80000000},
                     {96'd0, 32'hFFFFFFFF}, {224'd0, E_OVF_C}, 1'b0);
        vecs[6] = vecs[0];
        vecs[6].rnd = 1'b1;

        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int a = 0; a < 8; a++) begin
            reg_read(3'(a), s);
            check($sformatf("rst_reg%0d", a), s, 32'd0);
        end
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_done_irq", 32'(bus.done_irq), 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i), cyc);
            if (i == 0) check("v0_busy_le40", 32'(cyc <= 40), 32'd1);
        end

        // Zero X_LEN: error completion without memory traffic, then W1C per bit
        rnd_gnt = 1'b0;
        reg_write(3'd5, 32'd0);
        reg_write(3'd6, 32'd1);
        req0 = req_seen;
        reg_write(3'd0, 32'd1);
        c = 0;
        while (bus.done_irq !== 1'b1 && c < 2) begin
            @(negedge clock);
            c++;
        end
        check("zlen_done_3cyc", 32'(bus.done_irq), 32'd1);
        reg_read(3'd1, s);
        check("zlen_status", s, 32'd6);
        check("zlen_no_req", 32'(req_seen - req0), 32'd0);
        reg_write(3'd1, 32'd2);
        reg_read(3'd1, s);
        check("w1c_done", s, 32'd4);
        reg_write(3'd1, 32'd4);
        reg_read(3'd1, s);
        check("w1c_err", s, 32'd0);
        check("w1c_irq", 32'(bus.done_irq), 32'd0);

        // Writes to config and START while busy are ignored
        mem_fill(vecs[0]);
        rnd_gnt = 1'b1;
        program_vec(vecs[0]);
        reg_write(3'd0, 32'd1);
        reg_write(3'd2, 32'h99);
        reg_write(3'd5, 32'd1);
        reg_write(3'd0, 32'd1);
        reg_read(3'd1, s);
        check("busy_status", s, 32'd1);
        wait_done(2000, cyc);
        reg_read(3'd2, s);
        check("busy_xbase_kept", s, 32'h10);
        reg_read(3'd5, s);
        check("busy_xlen_kept", s, 32'd3);
        check_result(vecs[0], "busyw");

        // Reset while a request is outstanding, then a clean rerun
        mem_fill(vecs[6]);
        rnd_gnt = 1'b1;
        program_vec(vecs[6]);
        reg_write(3'd0, 32'd1);
        repeat (8) @(negedge clock);
        c = 0;
        while (bus.mem_req !== 1'b1 && c < 200) begin
            @(negedge clock);
            c++;
        end
        check("mid_req_seen", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req_drop", 32'(bus.mem_req), 32'd0);
        check("mid_rst_irq", 32'(bus.done_irq), 32'd0);
        @(negedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        reg_read(3'd1, s);
        check("mid_rst_status", s, 32'd0);
        reg_read(3'd7, s);
        check("mid_rst_out_cnt", s, 32'd0);
        run_vec(vecs[6], "rerun", cyc);

        check("stall_stable", 32'(stab_viol), 32'd0);
        check("stalls_seen", 32'(stab_checks > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
